// File: rtl/gnn_result_collector_if.sv
// Handshake and result bus between the GNN accelerator/host and the collector.
// The master side is the collector; the slave side is the host/accelerator.
interface gnn_result_collector_if #(
  parameter int DATA_W = 21,
  parameter int NSLOT  = 8,
  parameter int IW     = 3
);
  logic                    start;
  logic                    in_ready;
  logic [NSLOT*DATA_W-1:0] res_data;
  logic [NSLOT-1:0]        res_strobe;
  logic                    m_valid;
  logic                    m_ready;
  logic [DATA_W-1:0]       m_data;
  logic [IW-1:0]           m_idx;
  logic                    m_last;
  logic                    busy;
  logic                    done;
  logic                    timeout_err;

  modport master (
    input  start,
    input  res_data,
    input  res_strobe,
    input  m_ready,
    output in_ready,
    output m_valid,
    output m_data,
    output m_idx,
    output m_last,
    output busy,
    output done,
    output timeout_err
  );

  modport slave (
    output start,
    output res_data,
    output res_strobe,
    output m_ready,
    input  in_ready,
    input  m_valid,
    input  m_data,
    input  m_idx,
    input  m_last,
    input  busy,
    input  done,
    input  timeout_err
  );
endinterface

// File: rtl/gnn_result_collector.sv
// Launches a GNN inference, captures per-slot results on strobes,
// then drains them as an indexed valid/ready stream with hang timeout.
module gnn_result_collector #(
  parameter int DATA_W        = 21,
  parameter int NUM_NODES     = 4,
  parameter int OUTS_PER_NODE = 2,
  parameter int TIMEOUT       = 64,
  localparam int NSLOT = NUM_NODES * OUTS_PER_NODE,
  localparam int IW    = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
  input  logic clk,
  input  logic rst_n,
  gnn_result_collector_if.master bus
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_nstate;
  logic [NSLOT-1:0]  r_mask;
  logic [NSLOT-1:0]  w_mask_nxt;
  logic [NSLOT-1:0]  w_cap;
  logic [TW-1:0]     r_timer;
  logic [IW-1:0]     r_ptr;
  logic              r_done;
  logic              r_terr;
  logic [DATA_W-1:0] r_slot [NSLOT];

  logic w_launch;
  logic w_in_wait;
  logic w_full;
  logic w_tmo;
  logic w_xfer;
  logic w_ptr_last;
  logic w_expire;
  logic w_to_drain;
  logic w_last_xfer;
  logic w_valid;

  assign w_launch   = (r_state == S_IDLE) && bus.start;
  assign w_in_wait  = (r_state == S_WAIT);
  assign w_cap      = bus.res_strobe & ~r_mask
                    & {NSLOT{w_in_wait}};
  assign w_mask_nxt = r_mask | w_cap;
  assign w_full     = &w_mask_nxt;
  assign w_tmo      = (r_timer == TW'(TIMEOUT - 1));
  assign w_valid    = (r_state == S_DRAIN);
  assign w_xfer     = w_valid && bus.m_ready;
  assign w_ptr_last = (r_ptr == IW'(NSLOT - 1));

  always_comb begin
    w_nstate    = r_state;
    w_expire    = 1'b0;
    w_to_drain  = 1'b0;
    w_last_xfer = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_nstate = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_nstate = S_WAIT;
      end
      S_WAIT: begin
        // completion takes priority over expiry on the same edge
        if (w_full) begin
          w_nstate   = S_DRAIN;
          w_to_drain = 1'b1;
        end else if (w_tmo) begin
          w_nstate = S_IDLE;
          w_expire = 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_xfer && w_ptr_last) begin
          w_nstate    = S_IDLE;
          w_last_xfer = 1'b1;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_timer <= '0;
      r_ptr   <= '0;
      r_done  <= 1'b0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_done  <= w_last_xfer;
      if (w_launch) begin
        r_mask  <= '0;
        r_timer <= '0;
        r_terr  <= 1'b0;
      end else if (w_in_wait) begin
        r_mask  <= w_mask_nxt;
        r_timer <= r_timer + TW'(1);
      end
      if (w_expire) r_terr <= 1'b1;
      if (w_to_drain) begin
        r_ptr <= '0;
      end else if (w_xfer) begin
        r_ptr <= r_ptr + IW'(1);
      end
    end
  end

  // first strobe per slot wins; later strobes on a captured slot are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NSLOT; j++) r_slot[j] <= '0;
    end else begin
      for (int j = 0; j < NSLOT; j++) begin
        if (w_cap[j]) r_slot[j] <= bus.res_data[j*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.in_ready    = (r_state == S_LAUNCH);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.m_valid     = w_valid;
  assign bus.m_data      = w_valid ? r_slot[r_ptr] : '0;
  assign bus.m_idx       = w_valid ? r_ptr : '0;
  assign bus.m_last      = w_valid && w_ptr_last;
  assign bus.done        = r_done;
  assign bus.timeout_err = r_terr;

endmodule

// File: tb/tb_gnn_result_collector.sv
// Directed scoreboard bench for gnn_result_collector (TIMEOUT=16).
// Expected stream words are queued when results are strobed in.
module tb_gnn_result_collector;

  localparam int DW = 21;
  localparam int NS = 8;

  typedef struct {
    logic [2:0]    idx;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  gnn_result_collector_if #(.DATA_W(DW), .NSLOT(NS), .IW(3)) bus ();

  gnn_result_collector #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog obs=hang exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_all(input logic [DW-1:0] v [NS]);
    exp_t e;
    for (int j = 0; j < NS; j++) begin
      e.idx = 3'(j);
      e.data = v[j];
      e.last = (j == NS - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("in_ready_hi", bus.in_ready, 1);
    chk("busy_hi", bus.busy, 1);
    chk("terr_clr", bus.timeout_err, 0);
    tick();
    chk("in_ready_lo", bus.in_ready, 0);
  endtask

  task automatic strobe_all(input logic [DW-1:0] v [NS]);
    for (int j = 0; j < NS; j++) bus.res_data[j*DW +: DW] = v[j];
    bus.res_strobe = '1;
    push_all(v);
    tick();
    bus.res_strobe = '0;
    chk("first_valid", bus.m_valid, 1);
  endtask

  task automatic strobe1(input int j, input logic [DW-1:0] v);
    bus.res_data[j*DW +: DW] = v;
    bus.res_strobe = '0;
    bus.res_strobe[j] = 1'b1;
    tick();
    bus.res_strobe = '0;
  endtask

  task automatic drain(input bit bp);
    logic [7:0] pat;
    logic [DW-1:0] pd;
    logic [2:0] pi;
    logic pv, pl, rdy;
    int cyc, k;
    exp_t e;
    pat = 8'b1011_0100;
    cyc = 0;
    k = 0;
    while (sb_q.size() > 0 && cyc < 64) begin
      rdy = bp ? pat[k % 8] : 1'b1;
      k++;
      bus.m_ready = rdy;
      pv = bus.m_valid;
      pd = bus.m_data;
      pi = bus.m_idx;
      pl = bus.m_last;
      tick();
      cyc++;
      if (pv && rdy) begin
        e = sb_q.pop_front();
        chk("idx", 32'(pi), 32'(e.idx));
        chk("data", 32'(pd), 32'(e.data));
        chk("last", 32'(pl), 32'(e.last));
        if (sb_q.size() == 0) chk("done_pulse", bus.done, 1);
      end else if (pv) begin
        chk("hold_valid", bus.m_valid, 1);
        chk("hold_data", 32'(bus.m_data), 32'(pd));
        chk("hold_idx", 32'(bus.m_idx), 32'(pi));
      end
    end
    bus.m_ready = 1'b0;
    chk("drain_left", sb_q.size(), 0);
    chk("busy_lo", bus.busy, 0);
    chk("valid_lo", bus.m_valid, 0);
    tick();
    chk("done_lo", bus.done, 0);
  endtask

  task automatic full_run(input logic [DW-1:0] v [NS]);
    do_start();
    strobe_all(v);
    drain(1'b0);
  endtask

  initial begin
    logic [DW-1:0] v [NS];
    bus.start = 1'b0;
    bus.res_data = '0;
    bus.res_strobe = '0;
    bus.m_ready = 1'b0;
    #3;
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_inrdy", bus.in_ready, 0);
    chk("rst_terr", bus.timeout_err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: nominal, strobes two cycles after in_ready
    for (int j = 0; j < NS; j++) v[j] = DW'(1000 * j - 3000);
    do_start();
    tick();
    chk("wait_no_valid", bus.m_valid, 0);
    strobe_all(v);
    drain(1'b0);

    // 2: staggered order with duplicates
    for (int j = 0; j < NS; j++) v[j] = DW'(11 * j + 5);
    v[2] = DW'(100);
    do_start();
    strobe1(7, v[7]);
    strobe1(0, v[0]);
    strobe1(7, DW'(999));
    strobe1(3, v[3]);
    strobe1(1, v[1]);
    strobe1(2, v[2]);
    strobe1(6, v[6]);
    strobe1(2, DW'(200));
    strobe1(4, v[4]);
    chk("stag_wait", bus.m_valid, 0);
    push_all(v);
    strobe1(5, v[5]);
    chk("stag_valid", bus.m_valid, 1);
    drain(1'b0);

    // 3: backpressure
    for (int j = 0; j < NS; j++) v[j] = DW'(-77 * j - 1);
    do_start();
    strobe_all(v);
    drain(1'b1);

    // 4: timeout with slot 7 missing
    do_start();
    bus.res_strobe = 8'h7f;
    tick();
    bus.res_strobe = '0;
    for (int c = 0; c < 14; c++) begin
      bus.res_strobe = 8'h01;
      tick();
      chk("to_novalid", bus.m_valid, 0);
    end
    bus.res_strobe = '0;
    chk("to_pending", bus.timeout_err, 0);
    chk("to_busy", bus.busy, 1);
    tick();
    chk("to_err", bus.timeout_err, 1);
    chk("to_idle", bus.busy, 0);
    chk("to_valid", bus.m_valid, 0);
    tick();
    chk("to_sticky", bus.timeout_err, 1);
    for (int j = 0; j < NS; j++) v[j] = DW'(j * 3);
    full_run(v);

    // 5a: extremes round-trip
    for (int j = 0; j < NS; j++)
      v[j] = j[0] ? DW'(21'h0FFFFF) : DW'(21'h100000);
    full_run(v);

    // 5b: last strobe lands on the expiry edge
    for (int j = 0; j < NS; j++) v[j] = DW'(500 + j);
    do_start();
    for (int j = 0; j < NS; j++) bus.res_data[j*DW +: DW] = v[j];
    bus.res_strobe = 8'h7f;
    tick();
    bus.res_strobe = '0;
    for (int c = 0; c < 14; c++) tick();
    chk("sim_busy", bus.busy, 1);
    strobe_all(v);
    chk("sim_terr", bus.timeout_err, 0);
    drain(1'b0);

    // 6: reset mid-drain
    for (int j = 0; j < NS; j++) v[j] = DW'(-j);
    do_start();
    strobe_all(v);
    bus.m_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      tick();
      void'(sb_q.pop_front());
    end
    chk("rd_idx3", 32'(bus.m_idx), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rd_valid", bus.m_valid, 0);
    chk("rd_busy", bus.busy, 0);
    chk("rd_data", 32'(bus.m_data), 0);
    chk("rd_idx", 32'(bus.m_idx), 0);
    chk("rd_last", bus.m_last, 0);
    chk("rd_done", bus.done, 0);
    bus.m_ready = 1'b0;
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rd_nodone", bus.done, 0);
    tick();
    chk("rd_nodone2", bus.done, 0);
    for (int j = 0; j < NS; j++) v[j] = DW'(42 * j + 7);
    full_run(v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gnn_result_collector.md
Name: gnn_result_collector

Overview:
- Host-side counterpart to the GNN accelerator top: launches an inference by pulsing `in_ready`.
- Captures the eight 21-bit node outputs as their per-output ready strobes arrive.
- Once all results are held, drains them as an indexed stream over a valid/ready handshake.
- Sits between the accelerator top and the host/readout logic; detects a hung inference by timeout.

Parameters:
- DATA_W, 21, width of each signed result word
- NUM_NODES, 4, graph nodes
- OUTS_PER_NODE, 2, output features per node
- TIMEOUT, 64, max cycles in WAIT before error (must be >= 2)
- Derived: NSLOT = NUM_NODES*OUTS_PER_NODE; IW = $clog2(NSLOT)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new inference; sampled only in IDLE
- in_ready  output  1  launch pulse to accelerator, registered
- res_data  input  NSLOT*DATA_W  packed results; slot j = node*OUTS_PER_NODE + out (slot 0 = out0_node0, slot 1 = out1_node0, ..., slot 7 = out1_node3)
- res_strobe  input  NSLOT  per-slot ready flags (out1x_ready_nodeY), same slot order
- m_valid  output  1  stream word valid
- m_ready  input  1  downstream accepts
- m_data  output  DATA_W  signed result word
- m_idx  output  IW  slot index of m_data
- m_last  output  1  high with slot NSLOT-1
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse after final beat accepted
- timeout_err  output  1  sticky error flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE; capture mask, slot registers, timer and pointer cleared.
  - All outputs 0.
  - Release is synchronous to the next clk edge.
- States: IDLE, LAUNCH, WAIT, DRAIN.
- IDLE:
  - start=1 at edge k moves to LAUNCH; in_ready=1 for exactly the cycle after edge k.
  - Same edge clears timeout_err, mask and timer.
- LAUNCH: one cycle; strobes are ignored; next state is WAIT.
- WAIT:
  - Each edge, for every slot j with res_strobe[j]=1 and mask[j]=0: slot[j] <= res_data[j]; mask[j] <= 1.
  - Strobes on an already-captured slot are ignored; the first value is kept.
  - Strobe level vs pulse does not matter.
  - Timer increments each WAIT cycle.
  - If the updated mask is all ones: go to DRAIN, ptr=0.
  - Else, if timer reaches TIMEOUT-1: set timeout_err=1, go to IDLE, nothing emitted.
  - Completion and expiry on the same edge: completion wins.
- DRAIN:
  - m_valid=1, m_data=slot[ptr], m_idx=ptr, m_last=(ptr==NSLOT-1).
  - On m_valid && m_ready: ptr++.
  - On the last beat: go to IDLE, done=1 for the next cycle.
  - m_data/m_idx/m_last are held stable while m_valid && !m_ready.
  - m_valid never drops without a transfer, except on reset.
  - Strobes are ignored.
- start outside IDLE is ignored; there is no queuing.
- Words pass through unmodified (two's complement, no saturation).
- m_* outputs are registered from state/ptr; when m_valid=0, m_data/m_idx/m_last are 0.
- Latency:
  - start to in_ready: 1 cycle.
  - Completing strobe edge to first m_valid: 1 cycle.
  - Minimum drain: NSLOT cycles.
- Reset mid-operation: immediate return to IDLE; partial captures are discarded; no done pulse.

Test Plan:
1. Nominal:
   - Stimulus: reset, start pulse; 2 cycles after in_ready, all 8 strobes high for one cycle with slot j = 1000*j - 3000; m_ready=1.
   - Required: in_ready high exactly 1 cycle; m_idx 0..7 on consecutive cycles with data -3000, -2000, ..., 4000; m_last only on idx 7; done pulses once; busy falls.
2. Staggered and duplicate strobes:
   - Stimulus: strobes one slot per cycle in order 7,0,3,1,2,6,4,5; slot 2 strobed again later with 200 after first 100.
   - Required: drain in index order 0..7; slot 2 emits 100.
3. Backpressure:
   - Stimulus: m_ready pattern 0,0,1,0,1,1,0,1,... during DRAIN.
   - Required: m_data/m_idx constant across stalled cycles; exactly 8 transfers, no drop or duplicate.
4. Timeout (TIMEOUT=16):
   - Stimulus: slots 0-6 strobed, slot 7 never strobed.
   - Required: timeout_err=1 after 16 WAIT cycles; m_valid never asserted; state IDLE.
   - Follow-up: next start clears timeout_err; a full run then succeeds.
5. Extremes and simultaneous events:
   - Stimulus: results -1048576 (21'h100000) and 1048575 (21'h0FFFFF); separately, the last strobe on the timer-expiry edge.
   - Required: values round-trip bit-exact; the last-strobe case enters DRAIN with timeout_err=0.
6. Reset mid-DRAIN:
   - Stimulus: assert rst_n=0 after 3 beats, between clock edges.
   - Required: m_valid, busy and all outputs drop to 0 immediately; no done pulse; a fresh start after release performs a complete run.
